w_expand: RTL and testbench

//  SHA-256 message-schedule expander. Sits directly downstream of W_start.

---
 rtl/w_expand.sv | 92 +++++++++
 tb/tb_w_expand.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_expand.sv
// SHA-256 message-schedule expander: loads the 16-word initial schedule on an en
// rising edge and streams W_t for t = 0..ROUNDS-1, one word per accepted cycle.
module w_expand #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [511:0] W,
  input  logic         stall,
  output logic [31:0]  W_t,
  output logic [5:0]   t,
  output logic         valid,
  output logic         busy,
  output logic         en_next
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state, state_nx;
  logic        en_q;
  logic [31:0] win [16];
  logic        start;
  logic        advance;
  logic        last;
  logic [31:0] new_word;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign start    = en & ~en_q & (state == IDLE);
  assign last     = valid & (t == LAST_T);
  assign advance  = (state == RUN) & valid & ~stall;
  assign new_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (advance && last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == RUN);
    en_next = last;
  end

  // W_t always mirrors win[0]; the first RUN cycle only raises valid on the freshly loaded window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q  <= 1'b0;
      W_t   <= '0;
      t     <= '0;
      valid <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      en_q <= en;
      if (start) begin
        for (int i = 0; i < 16; i++) win[i] <= W[32*i +: 32];
      end else if (state == RUN && !valid) begin
        valid <= 1'b1;
        t     <= '0;
        W_t   <= win[0];
      end else if (advance) begin
        if (last) begin
          valid <= 1'b0;
          t     <= '0;
        end else begin
          for (int i = 0; i < 15; i++) win[i] <= win[i+1];
          win[15] <= new_word;
          t       <= t + 6'd1;
          W_t     <= win[1];
        end
      end
    end
  end

endmodule

// File: tb/tb_w_expand.sv
// Self-checking bench for w_expand: compares the streamed schedule against an
// array-based SHA-256 schedule model, with random stalls and mid-block events.
module tb_w_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [511:0] W;
  logic         stall;
  logic [31:0]  W_t;
  logic [5:0]   t;
  logic         valid;
  logic         busy;
  logic         en_next;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_w [64];
  logic [31:0] got_w [$];
  int          got_t [$];
  bit          run_timeout;
  int          enn_bad;
  int          busy_bad;

  localparam logic [31:0] HDR [16] = '{
    32'h02000000, 32'h17975b97, 32'hc18ed1f7, 32'he255adf2, 32'h97599b55, 32'h330edab8,
    32'h7d7de11a, 32'h15a907c0, 32'h8e2a7c91, 32'h3d6e2f0b, 32'h00000000, 32'h5b1e0f77,
    32'hd1c2a9e4, 32'h19ec3a6c, 32'h80000000, 32'h15a907c0};

  w_expand #(.ROUNDS(64)) dut (
    .clk(clk), .reset(reset), .en(en), .W(W), .stall(stall),
    .W_t(W_t), .t(t), .valid(valid), .busy(busy), .en_next(en_next)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule recurrence over a flat 64-entry array.
  task automatic compute_ref(input logic [511:0] blk);
    for (int i = 0; i < 64; i++) begin
      if (i < 16) ref_w[i] = blk[32*i +: 32];
      else ref_w[i] = (rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10))
                      + ref_w[i-7]
                      + (rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3))
                      + ref_w[i-16];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Starts a block with a fresh en edge and collects every accepted word; en is left high.
  task automatic run_block(input logic [511:0] blk, input int stall_pct);
    bit done = 0;
    int cyc  = 0;
    got_w.delete();
    got_t.delete();
    enn_bad  = 0;
    busy_bad = 0;
    W  = blk;
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (en_next !== (valid && t == 6'd63)) enn_bad++;
      if (valid === 1'b1 && busy !== 1'b1) busy_bad++;
      stall = ($urandom_range(99) < stall_pct);
      if (valid === 1'b1 && !stall) begin
        got_w.push_back(W_t);
        got_t.push_back(int'(t));
        if (t == 6'd63) done = 1;
      end
    end
    stall = 1'b0;
    run_timeout = !done;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; stall = 1'b0; W = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({W_t, t, valid, busy, en_next} !== 41'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got W_t=%h t=%0d v=%b b=%b n=%b want all zero",
               W_t, t, valid, busy, en_next);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_reset got v=%b b=%b want 0 0", valid, busy);
    end
  endtask

  task automatic test_zero_block();
    run_block('0, 0);
    total++;
    if (run_timeout || got_w.size() != 64) begin
      bad++;
      $display("[TB] FAIL zero_count got %0d words want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size(); i++) begin
      total++;
      if (got_w[i] !== 32'd0 || got_t[i] != i) begin
        bad++;
        $display("[TB] FAIL zero_word[%0d] got t=%0d W_t=%h want t=%0d W_t=0", i, got_t[i], got_w[i], i);
      end
    end
    total++;
    if (enn_bad != 0 || busy_bad != 0) begin
      bad++;
      $display("[TB] FAIL zero_flags got en_next errs=%0d busy errs=%0d want 0 0", enn_bad, busy_bad);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || en_next !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_done got b=%b v=%b n=%b want 0 0 0", busy, valid, en_next);
    end
    en = 1'b0;
  endtask

  task automatic test_single_bits();
    logic [511:0] blk;
    blk = '0;
    blk[0] = 1'b1;
    run_block(blk, 0);
    total++;
    if (run_timeout || got_w.size() != 64) begin
      bad++;
      $display("[TB] FAIL w0_count got %0d want 64", got_w.size());
    end else begin
      total++;
      if (got_w[0] !== 32'd1 || got_w[16] !== 32'd1 || got_w[23] !== 32'd1) begin
        bad++;
        $display("[TB] FAIL w0_ones got %h %h %h want 1 1 1", got_w[0], got_w[16], got_w[23]);
      end
      total++;
      if (got_w[18] !== 32'h0000A000) begin
        bad++;
        $display("[TB] FAIL w0_w18 got %h want 0000a000", got_w[18]);
      end
      total++;
      if (got_w[17] !== 32'd0 || got_w[19] !== 32'd0 || got_w[21] !== 32'd0) begin
        bad++;
        $display("[TB] FAIL w0_zeros got %h %h %h want 0 0 0", got_w[17], got_w[19], got_w[21]);
      end
    end
    blk = '0;
    blk[32] = 1'b1;
    run_block(blk, 0);
    total++;
    if (run_timeout || got_w.size() != 64) begin
      bad++;
      $display("[TB] FAIL w1_count got %0d want 64", got_w.size());
    end else begin
      total++;
      if (got_w[16] !== 32'h02004000 || got_w[17] !== 32'h00000001) begin
        bad++;
        $display("[TB] FAIL w1_words got W16=%h W17=%h want 02004000 00000001", got_w[16], got_w[17]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_header();
    logic [511:0] blk;
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = HDR[i];
    compute_ref(blk);
    run_block(blk, 0);
    total++;
    if (run_timeout || got_w.size() != 64) begin
      bad++;
      $display("[TB] FAIL hdr_count got %0d want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      total++;
      if (got_w[i] !== ref_w[i] || got_t[i] != i) begin
        bad++;
        $display("[TB] FAIL hdr_word[%0d] got t=%0d W_t=%h want t=%0d W_t=%h", i, got_t[i], got_w[i], i, ref_w[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_stall();
    logic [511:0] blk;
    logic [31:0]  hold_w;
    logic [5:0]   hold_t;
    bit           prev_stall = 0;
    bit           done = 0;
    int           n5 = 0, n63 = 0, cyc = 0;
    blk = rand_block();
    compute_ref(blk);
    got_w.delete();
    got_t.delete();
    W = blk; en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        total++;
        if (W_t !== hold_w || t !== hold_t || valid !== 1'b1) begin
          bad++;
          $display("[TB] FAIL stall_hold got t=%0d W_t=%h v=%b want t=%0d W_t=%h v=1", t, W_t, valid, hold_t, hold_w);
        end
      end
      stall = 1'b0;
      if (valid === 1'b1 && t == 6'd5 && n5 < 3) begin
        stall = 1'b1; n5++;
      end else if (valid === 1'b1 && t == 6'd63 && n63 < 3) begin
        stall = 1'b1; n63++;
      end
      if (valid === 1'b1 && t == 6'd63) begin
        total++;
        if (en_next !== 1'b1) begin
          bad++;
          $display("[TB] FAIL stall_en_next got %b want 1", en_next);
        end
      end
      prev_stall = stall;
      hold_w = W_t;
      hold_t = t;
      if (valid === 1'b1 && !stall) begin
        got_w.push_back(W_t);
        got_t.push_back(int'(t));
        if (t == 6'd63) done = 1;
      end
    end
    stall = 1'b0;
    total++;
    if (!done || got_w.size() != 64 || n5 != 3 || n63 != 3) begin
      bad++;
      $display("[TB] FAIL stall_count got %0d words stalls %0d/%0d want 64 words stalls 3/3", got_w.size(), n5, n63);
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      total++;
      if (got_w[i] !== ref_w[i] || got_t[i] != i) begin
        bad++;
        $display("[TB] FAIL stall_word[%0d] got t=%0d W_t=%h want t=%0d W_t=%h", i, got_t[i], got_w[i], i, ref_w[i]);
      end
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_abort();
    logic [511:0] blk;
    int cyc = 0;
    blk = rand_block();
    W = blk; en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    while (!(valid === 1'b1 && t == 6'd30) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc >= 200) begin
      bad++;
      $display("[TB] FAIL abort_reach got no t=30 within %0d cycles want t=30", cyc);
    end
    reset = 1'b0;
    en = 1'b0;
    #1;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0 || en_next !== 1'b0 || t !== 6'd0 || W_t !== 32'd0) begin
      bad++;
      $display("[TB] FAIL abort_async got v=%b b=%b n=%b t=%0d W_t=%h want all zero", valid, busy, en_next, t, W_t);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    blk = rand_block();
    compute_ref(blk);
    run_block(blk, 20);
    total++;
    if (run_timeout || got_w.size() != 64) begin
      bad++;
      $display("[TB] FAIL abort_restart_count got %0d want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      total++;
      if (got_w[i] !== ref_w[i] || got_t[i] != i) begin
        bad++;
        $display("[TB] FAIL abort_word[%0d] got t=%0d W_t=%h want t=%0d W_t=%h", i, got_t[i], got_w[i], i, ref_w[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_en_during_run();
    logic [511:0] blk;
    bit done = 0;
    int cyc = 0;
    int toggled = 0;
    blk = rand_block();
    compute_ref(blk);
    got_w.delete();
    got_t.delete();
    W = blk; en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (toggled == 1) begin
        en = 1'b1;
        toggled = 2;
        W = rand_block();
      end
      if (valid === 1'b1 && t == 6'd10 && toggled == 0) begin
        en = 1'b0;
        toggled = 1;
      end
      if (valid === 1'b1) begin
        got_w.push_back(W_t);
        got_t.push_back(int'(t));
        if (t == 6'd63) done = 1;
      end
    end
    total++;
    if (!done || got_w.size() != 64) begin
      bad++;
      $display("[TB] FAIL edge_run_count got %0d words want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      total++;
      if (got_w[i] !== ref_w[i] || got_t[i] != i) begin
        bad++;
        $display("[TB] FAIL edge_run_word[%0d] got t=%0d W_t=%h want t=%0d W_t=%h", i, got_t[i], got_w[i], i, ref_w[i]);
      end
    end
    repeat (4) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL edge_no_restart got v=%b b=%b want 0 0", valid, busy);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    logic [511:0] blk;
    for (int b = 0; b < 4; b++) begin
      blk = rand_block();
      compute_ref(blk);
      run_block(blk, 30);
      total++;
      if (run_timeout || got_w.size() != 64 || enn_bad != 0 || busy_bad != 0) begin
        bad++;
        $display("[TB] FAIL rand_blk%0d got %0d words enn=%0d busy=%0d want 64 0 0", b, got_w.size(), enn_bad, busy_bad);
      end
      for (int i = 0; i < got_w.size() && i < 64; i++) begin
        total++;
        if (got_w[i] !== ref_w[i] || got_t[i] != i) begin
          bad++;
          $display("[TB] FAIL rand_word[%0d.%0d] got t=%0d W_t=%h want t=%0d W_t=%h", b, i, got_t[i], got_w[i], i, ref_w[i]);
        end
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_single_bits();
    test_header();
    test_stall();
    test_abort();
    test_en_during_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
